uart_packet_echo: RTL and testbench

UART_PACKET_ECHO -- requirements
Module: uart_packet_echo

---
 rtl/uart_pkt_pkg.sv | 19 +
 rtl/tx_byte_slot.sv | 25 ++
 rtl/uart_packet_echo.sv | 105 ++++++++++
 tb/tb_uart_packet_echo.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg: shared state encoding and byte constants for the packet echo
package uart_pkt_pkg;
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, TRAILER} state_t;
  localparam logic [7:0] HDR_B0 = 8'h52;
  localparam logic [7:0] HDR_B1 = 8'h45;
  localparam logic [7:0] HDR_B2 = 8'h54;
  localparam logic [7:0] HDR_B3 = 8'h3A;
  localparam logic [7:0] TRAILER_BYTE = 8'h0A;
  localparam logic [7:0] SUB_BYTE = 8'h3F;
  localparam logic [7:0] DIGIT_LO = 8'h30;
  localparam logic [7:0] DIGIT_HI = 8'h39;
  localparam logic [2:0] HDR_LEN = 3'd4;
  function automatic logic [7:0] hdrByte(input logic [1:0] idx);
    return idx == 2'd0 ? HDR_B0 : idx == 2'd1 ? HDR_B1 : idx == 2'd2 ? HDR_B2 : HDR_B3;
  endfunction
  function automatic logic isDigit(input logic [7:0] b);
    return b >= DIGIT_LO && b <= DIGIT_HI;
  endfunction
endpackage

// File: rtl/tx_byte_slot.sv
// tx_byte_slot: one-entry valid/ready holding register feeding the UART TX
module tx_byte_slot (
  input  logic       sysClk,
  input  logic       sysRst,
  input  logic       load,
  input  logic [7:0] loadData,
  output logic [7:0] TxData,
  output logic       TxData_valid,
  input  logic       TxData_ready,
  output logic       canLoad
);
  assign canLoad = !TxData_valid || TxData_ready;
  // load takes priority so an accept and a reload in the same cycle leave no bubble
  always_ff @(posedge sysClk) begin
    if (sysRst) begin
      TxData <= 8'h00;
      TxData_valid <= 1'b0;
    end else if (load) begin
      TxData <= loadData;
      TxData_valid <= 1'b1;
    end else if (TxData_ready) begin
      TxData_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/uart_packet_echo.sv
// uart_packet_echo: pulls fixed-length packets from the RX FIFO and echoes them, raw or framed
module uart_packet_echo
  import uart_pkt_pkg::*;
#(
  parameter int PKT_LEN = 10,
  parameter int FILL_W = 11,
  parameter int TIMEOUT = 100000
) (
  input  logic              sysClk,
  input  logic              sysRst,
  input  logic [7:0]        RxData,
  input  logic              RxData_valid,
  output logic              RxData_ready,
  input  logic [FILL_W-1:0] RxFIFOFillLevel,
  output logic [7:0]        TxData,
  output logic              TxData_valid,
  input  logic              TxData_ready,
  input  logic              framed,
  output logic              busy,
  output logic [15:0]       pktCount,
  output logic [15:0]       errCount
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [7:0] popped;
  logic [2:0] hdrNext;
  logic [TW-1:0] idleCnt;
  logic modeFramed;
  logic canLoad, txAccept, pop, subst, timedOut, start, payloadDone, hdrLoad, trailerLoad, load;
  logic [7:0] loadData;
  assign txAccept = TxData_valid && TxData_ready;
  assign timedOut = idleCnt >= TW'(TIMEOUT);
  assign RxData_ready = state == PAYLOAD && popped < 8'(PKT_LEN) && canLoad && !timedOut;
  assign pop = RxData_valid && RxData_ready;
  assign subst = modeFramed && !isDigit(RxData);
  assign start = state == IDLE && RxFIFOFillLevel >= FILL_W'(PKT_LEN) && !TxData_valid;
  assign payloadDone = state == PAYLOAD && popped == 8'(PKT_LEN) && canLoad;
  assign hdrLoad = state == HDR && txAccept && hdrNext != HDR_LEN;
  assign trailerLoad = payloadDone && modeFramed;
  assign load = pop || hdrLoad || trailerLoad || (start && framed);
  assign busy = state != IDLE;
  // source of the next TX byte; the fallthrough is the first header byte on IDLE exit
  always_comb begin
    loadData = pop ? (subst ? SUB_BYTE : RxData) :
               trailerLoad ? TRAILER_BYTE :
               hdrLoad ? hdrByte(hdrNext[1:0]) : HDR_B0;
  end
  tx_byte_slot slot (
    .sysClk(sysClk),
    .sysRst(sysRst),
    .load(load),
    .loadData(loadData),
    .TxData(TxData),
    .TxData_valid(TxData_valid),
    .TxData_ready(TxData_ready),
    .canLoad(canLoad)
  );
  // packet sequencing, pop-timeout watchdog and statistics counters
  always_ff @(posedge sysClk) begin
    if (sysRst) begin
      state <= IDLE;
      popped <= 8'd0;
      hdrNext <= 3'd0;
      idleCnt <= '0;
      modeFramed <= 1'b0;
      pktCount <= 16'd0;
      errCount <= 16'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          modeFramed <= framed;
          state <= framed ? HDR : PAYLOAD;
          hdrNext <= 3'd1;
          popped <= 8'd0;
          idleCnt <= '0;
        end
        HDR: if (txAccept) begin
          if (hdrNext == HDR_LEN) begin
            state <= PAYLOAD;
            idleCnt <= '0;
          end else hdrNext <= hdrNext + 3'd1;
        end
        PAYLOAD: if (pop) begin
          popped <= popped + 8'd1;
          idleCnt <= '0;
          errCount <= errCount + 16'(subst && errCount != 16'hFFFF);
        end else begin
          if (!timedOut) idleCnt <= idleCnt + 1'b1;
          if (payloadDone) begin
            state <= modeFramed ? TRAILER : IDLE;
            pktCount <= pktCount + 16'(!modeFramed);
          end else if (timedOut && canLoad) begin
            state <= IDLE;
            errCount <= errCount + 16'(errCount != 16'hFFFF);
          end
        end
        TRAILER: if (txAccept) begin
          state <= IDLE;
          pktCount <= pktCount + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_packet_echo.sv
// tb_uart_packet_echo: directed checks of raw/framed echo, fill gating, stalls, timeout and reset
module tb_uart_packet_echo;
  logic sysClk = 1'b0;
  logic sysRst;
  logic [7:0] RxData;
  logic RxData_valid;
  logic RxData_ready;
  logic [10:0] RxFIFOFillLevel;
  logic [7:0] TxData;
  logic TxData_valid;
  logic TxData_ready;
  logic framed;
  logic busy;
  logic [15:0] pktCount;
  logic [15:0] errCount;
  uart_packet_echo #(.PKT_LEN(10), .FILL_W(11), .TIMEOUT(50)) dut (
    .sysClk(sysClk),
    .sysRst(sysRst),
    .RxData(RxData),
    .RxData_valid(RxData_valid),
    .RxData_ready(RxData_ready),
    .RxFIFOFillLevel(RxFIFOFillLevel),
    .TxData(TxData),
    .TxData_valid(TxData_valid),
    .TxData_ready(TxData_ready),
    .framed(framed),
    .busy(busy),
    .pktCount(pktCount),
    .errCount(errCount)
  );
  always #5 sysClk = ~sysClk;
  logic [7:0] rxQ[$];
  logic [7:0] txLog[$];
  int nTests = 0;
  int nFail = 0;
  int readyMode = 1;
  bit forceFill = 0;
  int forceVal = 0;
  bit popNow, stallPrev, rstPrev;
  logic [7:0] stallData;
  int stallBad = 0;
  int dropBad = 0;
  int actCnt = 0;
  int since = 0;
  int n;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic drive();
    RxData = rxQ.size() > 0 ? rxQ[0] : 8'h00;
    RxData_valid = rxQ.size() > 0;
    RxFIFOFillLevel = forceFill ? 11'(forceVal) : 11'(rxQ.size());
    TxData_ready = readyMode == 2 ? ($urandom_range(0, 99) < 30) : readyMode == 1;
  endtask
  task automatic step();
    @(negedge sysClk);
    popNow = RxData_valid && RxData_ready;
    if (TxData_valid && TxData_ready) txLog.push_back(TxData);
    if (stallPrev && !rstPrev && TxData_valid && TxData != stallData) stallBad++;
    if (stallPrev && !rstPrev && !TxData_valid) dropBad++;
    if (RxData_ready || TxData_valid) actCnt++;
    stallPrev = TxData_valid && !TxData_ready;
    stallData = TxData;
    rstPrev = sysRst;
    @(posedge sysClk);
    #1;
    if (popNow) void'(rxQ.pop_front());
    drive();
  endtask
  task automatic doReset();
    sysRst = 1'b1;
    step();
    sysRst = 1'b0;
    rxQ.delete();
    txLog.delete();
    drive();
  endtask
  task automatic pushStr(input string s);
    for (int i = 0; i < s.len(); i++) rxQ.push_back(s[i]);
    drive();
  endtask
  task automatic runUntilPkt(input int bound);
    int k = 0;
    while (pktCount == 16'd0 && k < bound) begin
      step();
      k++;
    end
    chk("pkt_wait", pktCount, 1);
    repeat (3) step();
  endtask
  task automatic checkLog(input string tag, input string exp);
    chk({tag, "_len"}, txLog.size(), exp.len());
    for (int i = 0; i < exp.len() && i < txLog.size(); i++) chk(tag, txLog[i], exp[i]);
  endtask
  initial begin
    sysRst = 1'b1;
    framed = 1'b0;
    drive();
    step();
    step();
    sysRst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_txvalid", TxData_valid, 0);
    chk("rst_txdata", TxData, 0);
    chk("rst_rxready", RxData_ready, 0);
    chk("rst_pkt", pktCount, 0);
    chk("rst_err", errCount, 0);
    // raw echo, TX always ready
    pushStr("0123456789");
    runUntilPkt(100);
    checkLog("raw_byte", "0123456789");
    chk("raw_pkt", pktCount, 1);
    chk("raw_err", errCount, 0);
    chk("raw_busy", busy, 0);
    // framed echo with one non-digit; framed dropped mid-packet has no effect
    doReset();
    framed = 1'b1;
    pushStr("01a3456789");
    step();
    step();
    framed = 1'b0;
    runUntilPkt(100);
    checkLog("frm_byte", "RET:01?3456789\n");
    chk("frm_pkt", pktCount, 1);
    chk("frm_err", errCount, 1);
    chk("frm_busy", busy, 0);
    // one byte short of a packet: nothing may happen
    doReset();
    pushStr("012345678");
    actCnt = 0;
    repeat (1000) step();
    chk("fill9_idle", actCnt, 0);
    chk("fill9_busy", busy, 0);
    rxQ.push_back(8'h39);
    drive();
    n = 0;
    while (!RxData_ready && n < 3) begin
      step();
      n++;
    end
    chk("fill10_start", RxData_ready && n <= 2, 1);
    runUntilPkt(100);
    checkLog("fill10_byte", "0123456789");
    // random TX back-pressure
    doReset();
    stallBad = 0;
    dropBad = 0;
    readyMode = 2;
    pushStr("0123456789");
    runUntilPkt(1000);
    readyMode = 1;
    drive();
    checkLog("stall_byte", "0123456789");
    chk("stall_stable", stallBad, 0);
    chk("stall_nodrop", dropBad, 0);
    chk("stall_err", errCount, 0);
    // RX starves after 4 pops with fill forced to a full packet
    doReset();
    forceFill = 1;
    forceVal = 10;
    pushStr("0123");
    since = 0;
    n = 0;
    step();
    while (busy && n < 300) begin
      step();
      since = popNow ? 0 : since + 1;
      n++;
    end
    forceFill = 0;
    drive();
    chk("to_idle", busy, 0);
    chk("to_window", since >= 50 && since <= 52, 1);
    chk("to_err", errCount, 1);
    chk("to_pkt", pktCount, 0);
    chk("to_sent", txLog.size(), 4);
    repeat (3) step();
    chk("to_stay_idle", busy, 0);
    // reset after the third payload byte is accepted
    doReset();
    pushStr("0123456789");
    n = 0;
    while (txLog.size() < 3 && n < 50) begin
      step();
      n++;
    end
    chk("mid_three", txLog.size(), 3);
    readyMode = 0;
    drive();
    sysRst = 1'b1;
    step();
    sysRst = 1'b0;
    chk("mid_txvalid", TxData_valid, 0);
    chk("mid_pkt", pktCount, 0);
    chk("mid_err", errCount, 0);
    chk("mid_busy", busy, 0);
    readyMode = 1;
    drive();
    repeat (30) step();
    chk("mid_no_tx", txLog.size(), 3);
    chk("mid_no_rx", actCnt > 0 && !busy, 1);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
